// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 7-10).
module e_muldiv #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        res,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU:                     is_mul_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  is_mul_op = 1'b1;
`endif
      default:                               is_mul_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: is_div_op = 1'b1;
      default:         is_div_op = 1'b0;
    endcase
  endfunction

  logic [3:0]  cnt_r, cnt_nx_s;
  logic [3:0]  op_r, op_nx_s;
  logic [31:0] a_r, a_nx_s;
  logic [31:0] b_r, b_nx_s;
  logic [31:0] hi_r, hi_nx_s;
  logic [31:0] lo_r, lo_nx_s;
  logic        busy_r, busy_nx_s;

  logic        start_s;
  logic [3:0]  lat_s;
  logic [63:0] prod_s_s, prod_u_s;
  logic [31:0] a_mag_s, b_mag_s, div_n_s, div_d_s, quo_s, rem_s;
  logic        sdiv_s;
  logic [31:0] commit_hi_s, commit_lo_s;

  assign start_s = is_mul_op(E_op) | is_div_op(E_op);
  assign lat_s   = is_div_op(E_op) ? DIV_LAT : MULT_LAT;
  assign E_start = start_s;

  // Both products are taken modulo 2^64, which is exact for 32x32 operands.
  assign prod_s_s = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
  assign prod_u_s = {32'd0, a_r} * {32'd0, b_r};

  // One shared unsigned divider; DIV runs on magnitudes and fixes signs afterwards.
  assign sdiv_s  = (op_r == OP_DIV);
  assign a_mag_s = a_r[31] ? (32'd0 - a_r) : a_r;
  assign b_mag_s = b_r[31] ? (32'd0 - b_r) : b_r;
  assign div_n_s = sdiv_s ? a_mag_s : a_r;
  assign div_d_s = sdiv_s ? b_mag_s : b_r;
  assign quo_s   = div_n_s / div_d_s;
  assign rem_s   = div_n_s % div_d_s;

  // Result to be written into HI/LO when the in-flight op completes.
  always_comb begin
    commit_hi_s = hi_r;
    commit_lo_s = lo_r;
    case (op_r)
      OP_MULT:  {commit_hi_s, commit_lo_s} = prod_s_s;
      OP_MULTU: {commit_hi_s, commit_lo_s} = prod_u_s;
      OP_DIV: begin
        if (b_r != 32'd0) begin
          commit_lo_s = (a_r[31] ^ b_r[31]) ? (32'd0 - quo_s) : quo_s;
          commit_hi_s = a_r[31] ? (32'd0 - rem_s) : rem_s;
        end else begin
          commit_hi_s = hi_r;
          commit_lo_s = lo_r;
        end
      end
      OP_DIVU: begin
        if (b_r != 32'd0) begin
          commit_lo_s = quo_s;
          commit_hi_s = rem_s;
        end else begin
          commit_hi_s = hi_r;
          commit_lo_s = lo_r;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {commit_hi_s, commit_lo_s} = {hi_r, lo_r} + prod_s_s;
      OP_MADDU: {commit_hi_s, commit_lo_s} = {hi_r, lo_r} + prod_u_s;
      OP_MSUB:  {commit_hi_s, commit_lo_s} = {hi_r, lo_r} - prod_s_s;
      OP_MSUBU: {commit_hi_s, commit_lo_s} = {hi_r, lo_r} - prod_u_s;
`endif
      default: begin
        commit_hi_s = hi_r;
        commit_lo_s = lo_r;
      end
    endcase
  end

  // Next-state: accept ops while idle, count down while busy, commit on the last count.
  always_comb begin
    cnt_nx_s = cnt_r;
    op_nx_s  = op_r;
    a_nx_s   = a_r;
    b_nx_s   = b_r;
    hi_nx_s  = hi_r;
    lo_nx_s  = lo_r;
    if (cnt_r == 4'd0) begin
      if (start_s) begin
        op_nx_s  = E_op;
        a_nx_s   = E_A;
        b_nx_s   = E_B;
        cnt_nx_s = lat_s;
      end else if (E_op == OP_MTHI) begin
        hi_nx_s = E_A;
      end else if (E_op == OP_MTLO) begin
        lo_nx_s = E_A;
      end else begin
        cnt_nx_s = 4'd0;
      end
    end else if (cnt_r == 4'd1) begin
      hi_nx_s = commit_hi_s;
      lo_nx_s = commit_lo_s;
      // A start presented on the commit edge is accepted back-to-back.
      if (start_s) begin
        op_nx_s  = E_op;
        a_nx_s   = E_A;
        b_nx_s   = E_B;
        cnt_nx_s = lat_s;
      end else begin
        cnt_nx_s = 4'd0;
      end
    end else begin
      cnt_nx_s = cnt_r - 4'd1;
    end
    busy_nx_s = (cnt_nx_s != 4'd0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      cnt_r  <= 4'd0;
      op_r   <= 4'd0;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nx_s;
      op_r   <= op_nx_s;
      a_r    <= a_nx_s;
      b_r    <= b_nx_s;
      hi_r   <= hi_nx_s;
      lo_r   <= lo_nx_s;
      busy_r <= busy_nx_s;
    end
  end

  assign E_busy = busy_r;
  assign E_HI   = hi_r;
  assign E_LO   = lo_r;

endmodule

// File: doc/e_muldiv.md
# e_muldiv

Multi-cycle multiply/divide unit in the E stage that owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, holds busy for a fixed latency, then commits HI/LO. Its HI/LO values feed the MFHI/MFLO path, and the result travels down through the M and W pipeline registers. The hazard unit stalls D-stage HI/LO instructions while `E_start | E_busy`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops, 1..15.
- `DIV_CYCLES`, default 10: busy cycles for divide ops, 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `res` in 1: reset, synchronous, active-low; `res==0` at a rising edge resets the unit.
- `E_op` in 4: operation code.
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU: only with the macro.
  - All other codes are NONE.
- `E_A` in 32: rs operand.
- `E_B` in 32: rt operand.
- `E_start` out 1: combinational; 1 when `E_op` is a multi-cycle op (1–4, plus 7–10 when enabled).
- `E_busy` out 1: registered; 1 while an operation is in flight.
- `E_HI` out 32: architectural HI register.
- `E_LO` out 32: architectural LO register.

## Operation
- **Reset:** on a `res==0` edge, HI, LO, counter and operand latches go to 0, so `E_busy=0`. Reset aborts any in-flight operation and no commit occurs.
- **Idle state (`counter==0`):**
  - Multi-cycle op: latch `E_A`, `E_B` and the op, then load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - MTHI: `HI<=E_A` at that edge; LO unchanged.
  - MTLO: `LO<=E_A` at that edge; HI unchanged.
  - NONE: no change.
- **Busy state (`counter!=0`):**
  - Every edge decrements the counter.
  - On the edge where the counter equals 1, commit the latched result to HI/LO and set the counter to 0.
  - Any `E_op` presented while busy is ignored, including MTHI/MTLO. Stalling it is the hazard unit's responsibility.
- **Arithmetic**, using the latched operands:
  - MULT: {HI,LO} = signed A × signed B, 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B==0): the op is accepted and busy runs the full `DIV_CYCLES`, but HI/LO are left unchanged at commit.
- HI/LO never change on any edge other than reset, an idle MTHI/MTLO, or a commit.

## Timing
- Start accepted at edge t0.
- `E_busy` is high in the cycles after edges t0 .. t0+N−1, i.e. exactly N cycles, where N is the op's latency.
- New HI/LO are visible from edge t0+N. `E_busy` falls at that same edge.
- Back-to-back: a new start can be accepted at edge t0+N, the same edge as the commit. The new op latches fresh operands; the commit of the old result still occurs.
- MTHI/MTLO take effect in 1 edge with no busy.
- `E_start` depends only on `E_op` (no state).
- Reset mid-operation: outputs are 0 from the next cycle; a later start behaves as from idle.

## Configuration
- `MDU_MADD_EN` defined: ops 7–10 are decoded as multiply-class with `MULT_CYCLES` latency.
  - MADD: {HI,LO} += signed A×B.
  - MADDU: {HI,LO} += unsigned A×B.
  - MSUB: {HI,LO} −= signed A×B.
  - MSUBU: {HI,LO} −= unsigned A×B.
  - The add/subtract is 64-bit modulo, using the {HI,LO} value current at the commit edge.
- `MDU_MADD_EN` undefined: codes 7–10 act as NONE, `E_start=0` for them, and no accumulate datapath is present.

## Test plan
- Reset (`res=0`, 2 cycles) after MTHI 0x1234 → `E_HI=E_LO=0`, `E_busy=0`. With `res=0` asserted 3 cycles into a DIV → no commit, `E_busy=0` next cycle.
- MULT A=0xFFFFFFFE (−2), B=3 → `E_busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with B=0 → HI/LO unchanged after 10 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MTLO 0x55 issued while busy → ignored; LO equals the product.
- Back-to-back: MULTU 2×3, then MULT 4×5 presented at the commit edge → LO=6 at that edge, LO=20 after 5 more edges, `E_busy` continuously high.
- With `MDU_MADD_EN`: MTLO 10, then MADD 3×4 → LO=22, HI=0. MSUBU 1×23 → {HI,LO}=0xFFFFFFFF_FFFFFFFF. Without the macro: op 7 → `E_start=0`, no change.
